// File: rtl/pattern_scan_ctrl.sv
// Purpose: word-at-a-time controller around a serial Moore pattern detector.
// Latency: WIDTH cycles from accepted start to the one-cycle done pulse; hit/count lag each bit by 1 cycle.
// Backpressure: none; start is only honoured in IDLE and ignored while busy or done.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset
//   start  - pass request, sampled in IDLE only
//   data   - WIDTH-bit word, scanned MSB first, captured on accept
//   pat    - PLEN-bit pattern, captured on accept
//   ovl    - 1 = overlapping matches, 0 = non-overlapping, captured on accept
//   busy   - high while bits are being shifted
//   done   - one-cycle pulse when the pass completes
//   hit    - Moore match output, decoded from registered state only
//   count  - matches in the current/last pass, held until the next accept
module pattern_scan_ctrl #(
    parameter int WIDTH = 16,
    parameter int PLEN  = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [PLEN-1:0]  pat,
    input  logic             ovl,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [CW-1:0]    count
);

    localparam int            VW        = $clog2(PLEN + 1);
    localparam logic [VW-1:0] VFULL     = VW'(PLEN);
    localparam logic [CW-1:0] BITS_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [PLEN-1:0]  hist;
    logic [PLEN-1:0]  pat_q;
    logic             ovl_q;
    logic [VW-1:0]    vcnt;    // number of valid history bits, saturating at PLEN
    logic [CW-1:0]    bitcnt;

    logic [PLEN-1:0]  hist_nxt;
    logic [VW-1:0]    vcnt_nxt;
    logic             hit_nxt;

    // A match needs a full window of bits collected since the pass began
    // (or, in non-overlapping mode, since the previous match).
    assign hit = (hist == pat_q) && (vcnt == VFULL);

    // Look-ahead of the detector so count can move on the same edge that
    // raises hit, keeping both aligned to the same bit.
    always_comb begin
        hist_nxt = {hist[PLEN-2:0], shreg[WIDTH-1]};
        if (!ovl_q && hit) begin
            // The incoming bit is the first bit of a fresh window.
            vcnt_nxt = VW'(1);
        end else if (vcnt == VFULL) begin
            vcnt_nxt = VFULL;
        end else begin
            vcnt_nxt = vcnt + VW'(1);
        end
        hit_nxt = (hist_nxt == pat_q) && (vcnt_nxt == VFULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            shreg  <= '0;
            hist   <= '0;
            pat_q  <= '0;
            ovl_q  <= 1'b0;
            vcnt   <= '0;
            bitcnt <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SHIFT;
                        busy   <= 1'b1;
                        shreg  <= data;
                        pat_q  <= pat;
                        ovl_q  <= ovl;
                        hist   <= '0;
                        vcnt   <= '0;
                        bitcnt <= '0;
                        count  <= '0;
                    end
                end
                SHIFT: begin
                    hist   <= hist_nxt;
                    shreg  <= {shreg[WIDTH-2:0], 1'b0};
                    vcnt   <= vcnt_nxt;
                    bitcnt <= bitcnt + CW'(1);
                    if (hit_nxt && (count != CNT_MAX)) begin
                        count <= count + CW'(1);
                    end
                    if (bitcnt == BITS_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    // hist/vcnt are left alone so hit holds its final value.
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Sequences a serial pattern-detection pass over a parallel word. A start request loads a WIDTH-bit word and a PLEN-bit pattern, then shifts the word MSB-first through a programmable Moore-style pattern detector, one bit per clock. The detector runs in overlapping or non-overlapping mode. When the pass ends, the block reports the match count with a one-cycle done pulse. It is the controller that turns the free-running serial detectors in this design into a word-at-a-time resource that upstream logic can start and poll.

## Interface
Parameters:
- WIDTH, 16: bits per scanned word; must be at least PLEN.
- PLEN, 4: pattern length in bits; must be at least 2.
- CW, $clog2(WIDTH+1): width of the match counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a pass; sampled only in IDLE.
- data  input  WIDTH  word to scan; captured when start is accepted.
- pat  input  PLEN  pattern to detect; captured when start is accepted.
- ovl  input  1  match mode, captured when start is accepted: 1 = overlapping, 0 = non-overlapping.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse in the DONE state.
- hit  output  1  Moore output: high while the detector state is a full match.
- count  output  CW  matches found in the current or last pass; held until the next accepted start.

## Operation
- State machine: IDLE, SHIFT, DONE.
- IDLE -> SHIFT when start=1. On that edge:
  - capture data into shreg, and capture pat and ovl;
  - clear hist (PLEN bits), vcnt, bitcnt and count.
- SHIFT: each edge does the following.
  - Shift shreg[WIDTH-1] into hist[0]; hist shifts toward its MSB.
  - Shift shreg left and increment bitcnt.
  - Update vcnt:
    - non-overlapping mode with hit=1 before the edge: vcnt becomes 1;
    - otherwise: vcnt = min(vcnt+1, PLEN).
  - count increments on any edge whose next state gives hit=1.
- SHIFT -> DONE on the edge that shifts the last bit (bitcnt reaches WIDTH).
- DONE -> IDLE unconditionally on the next edge.
- hit = (hist == pat) && (vcnt == PLEN). It is decoded from state registers only, with no combinational path from inputs.
- Overlapping mode: a match's trailing bits can start the next match. Non-overlapping mode: after a match, PLEN fresh bits are needed.
- busy = (state == SHIFT); done = (state == DONE).
- count saturates at 2^CW-1. It cannot overflow for legal parameters.
- hit stays at its final value through DONE, then clears only when the next pass starts.
- Reset sets state to IDLE and clears shreg, hist, vcnt, bitcnt and count. Outputs after reset: busy=0, done=0, hit=0, count=0.

## Timing
- Edge E0 accepts start; busy=1 from E0.
- Edge Ek (k = 1..WIDTH) shifts data bit WIDTH-k.
- hit and count reflect bit WIDTH-k immediately after Ek, giving a 1-cycle Moore latency from each bit.
- done is high for exactly one cycle, after E_WIDTH. busy falls at E_WIDTH.
- start-to-done latency is WIDTH edges. The next start is accepted at the earliest at E_WIDTH+2, the first IDLE cycle.
- start while in SHIFT or DONE is ignored; data, pat and ovl changes are ignored outside the accept edge.
- rst asserted mid-pass aborts immediately: no done pulse, count=0. After rst deasserts, the block idles until a new start.
- start held high continuously starts back-to-back passes with one IDLE cycle between them.

## Test plan
- Reset with start=0 -> busy=0, done=0, hit=0, count=0; outputs stay there for 10 cycles.
- data=16'hAAAA, pat=4'b1010, ovl=1 -> hit pulses after E4, E6, ..., E16; done after E16; count=7.
- data=16'hAAAA, pat=4'b1010, ovl=0 -> hit after E4, E8, E12, E16; count=4.
- data=16'hA5A5, pat=4'b1010, ovl=1 -> hit only after E4 and E12; count=2.
- data=16'h0000, pat=4'b1010 -> hit never asserts; count=0; done after E16.
- Start a 16'hAAAA overlapping pass, drive start with 16'h0000 at E5, then assert rst at E10 on a second pass:
  - first pass: count=7 with a single done (the E5 start is ignored);
  - second pass: done never pulses and count=0 after reset.
